// File: rtl/poly_addsub_ctrl_if.sv
// rtl/poly_addsub_ctrl_if.sv - read/write port bundle for the mod-q poly add/sub sequencer
// i_* are driven into the sequencer, o_* come out of it.
interface poly_addsub_ctrl_if #(
  parameter int N  = 256,
  parameter int AW = $clog2(N)
);
  logic          i_start;
  logic          i_op;
  logic          i_stall;
  logic [11:0]   i_a_data;
  logic [11:0]   i_b_data;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [11:0]   o_wr_data;
  logic          o_busy;
  logic          o_done;

  modport slave (
    input  i_start, i_op, i_stall, i_a_data, i_b_data,
    output o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
  );

  modport master (
    output i_start, i_op, i_stall, i_a_data, i_b_data,
    input  o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
  );
endinterface

// File: rtl/poly_addsub_ctrl.sv
// rtl/poly_addsub_ctrl.sv - sequencer for coefficient-wise C = A +/- B mod Q over external RAMs
// Reads issue on o_rd_en, data returns one cycle later, result is written two cycles after the read.
module poly_addsub_ctrl #(
  parameter int N = 256,
  parameter int Q = 3329
) (
  input  logic              clk,
  input  logic              rst,
  poly_addsub_ctrl_if.slave bus
);
  localparam int          AW = $clog2(N);
  localparam logic [12:0] QW = 13'(Q);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_op;
  logic          w_op_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          r_rd_en;
  logic          w_rd_en_nxt;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] w_rd_addr_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          w_launch;
  logic [AW-1:0] w_base;

  logic          r_s1_vld;
  logic [AW-1:0] r_s1_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [11:0]   r_wr_data;

  logic [12:0]   w_sum;
  logic [12:0]   w_dif;
  logic [11:0]   w_sum_red;
  logic [11:0]   w_dif_red;
  logic [11:0]   w_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= 1'b0;
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Reads are decided one edge ahead so every output stays a flop; a start edge launches address 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_cnt_nxt     = r_cnt;
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_launch      = 1'b0;
    w_base        = r_cnt;

    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (bus.i_start) begin
          w_op_nxt    = bus.i_op;
          w_state_nxt = S_RUN;
          w_launch    = 1'b1;
          w_base      = '0;
        end
      end
      S_RUN: begin
        w_launch = 1'b1;
      end
      S_DRAIN: begin
        // r_rd_en and r_s1_vld feed the two pipeline valid flops on this edge
        if (!r_rd_en && !r_s1_vld) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_launch) begin
      w_cnt_nxt = w_base;
      if (!bus.i_stall) begin
        w_rd_en_nxt   = 1'b1;
        w_rd_addr_nxt = w_base;
        if (w_base == AW'(N - 1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = w_base + AW'(1);
        end
      end
    end

    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_comb begin
    w_sum     = {1'b0, bus.i_a_data} + {1'b0, bus.i_b_data};
    w_sum_red = (w_sum >= QW) ? 12'(w_sum - QW) : w_sum[11:0];
    w_dif     = {1'b0, bus.i_a_data} - {1'b0, bus.i_b_data};
    w_dif_red = w_dif[12] ? 12'(w_dif + QW) : w_dif[11:0];
    w_result  = r_op ? w_dif_red : w_sum_red;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_s1_vld  <= r_rd_en;
      r_s1_addr <= r_rd_addr;
      r_wr_en   <= r_s1_vld;
      if (r_s1_vld) begin
        r_wr_addr <= r_s1_addr;
        r_wr_data <= w_result;
      end
    end
  end

  assign bus.o_rd_en   = r_rd_en;
  assign bus.o_rd_addr = r_rd_addr;
  assign bus.o_wr_en   = r_wr_en;
  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
endmodule

// File: tb/tb_poly_addsub_ctrl.sv
// tb/tb_poly_addsub_ctrl.sv - scoreboard bench for poly_addsub_ctrl
// Expected writes are queued per run; the monitor pops one entry on every wr_en.
module tb_poly_addsub_ctrl;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int Q  = 3329;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_addsub_ctrl_if #(.N(N)) dif ();
  poly_addsub_ctrl #(.N(N), .Q(Q)) dut (.clk(clk), .rst(rst), .bus(dif));

  logic [11:0] mem_a [N];
  logic [11:0] mem_b [N];
  logic [19:0] sb_q [$];
  int checks   = 0;
  int failures = 0;

  always @(posedge clk) begin
    if (dif.o_rd_en === 1'b1) begin
      dif.i_a_data <= mem_a[dif.o_rd_addr];
      dif.i_b_data <= mem_b[dif.o_rd_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input int data);
    logic [7:0]  a8;
    logic [11:0] d12;
    a8  = addr[7:0];
    d12 = data[11:0];
    sb_q.push_back({a8, d12});
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst && dif.o_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", 32'(dif.o_wr_addr), 32'(e[19:12]));
        chk("wr_data", 32'(dif.o_wr_data), 32'(e[11:0]));
      end
    end
  end

  task automatic fill_lin();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 12'(i);
      mem_b[i] = 12'd3328;
      push(i, (i == 0) ? 3328 : i - 1);
    end
  endtask

  task automatic fill_sub_corner();
    for (int i = 4; i < N; i++) begin
      mem_a[i] = 12'(i);
      mem_b[i] = 12'(2 * i);
    end
    mem_a[0] = 12'd5;  mem_b[0] = 12'd7;
    mem_a[1] = 12'd7;  mem_b[1] = 12'd5;
    mem_a[2] = 12'd0;  mem_b[2] = 12'd0;
    mem_a[3] = 12'd0;  mem_b[3] = 12'd3328;
    push(0, 3327); push(1, 2); push(2, 0); push(3, 1);
    for (int i = 4; i < N; i++) push(i, 3329 - i);
  endtask

  // Shared by an add run and the sub run chained onto its done cycle.
  task automatic fill_add_corner_chain();
    for (int i = 3; i < N; i++) begin
      mem_a[i] = 12'(i);
      mem_b[i] = 12'(i);
    end
    mem_a[0] = 12'd3328; mem_b[0] = 12'd3328;
    mem_a[1] = 12'd3328; mem_b[1] = 12'd1;
    mem_a[2] = 12'd1664; mem_b[2] = 12'd1664;
    push(0, 3327); push(1, 0); push(2, 3328);
    for (int i = 3; i < N; i++) push(i, 2 * i);
    push(0, 0); push(1, 3327); push(2, 0);
    for (int i = 3; i < N; i++) push(i, 0);
  endtask

  task automatic run_op(input string tag, input bit opv, input bit chained, input bit do_stall,
                        input bit do_mid, input bit chain_next, input bit next_op, input int exp_done);
    int k = 0;
    int first_rd = -1, last_rd = -1, first_wr = -1, last_wr = -1;
    int n_rd = 0, n_wr = 0, busy_bad = 0, stall_bad = 0, done_k = -1, stall_left = 0;
    bit stalled = 1'b0;
    if (!chained) begin
      @(negedge clk);
      dif.i_start = 1'b1;
      dif.i_op    = opv;
    end
    while (done_k < 0 && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        dif.i_start = 1'b0;
        chk({tag, "_first_rd_addr"}, 32'(dif.o_rd_addr), 32'd0);
      end
      if (do_mid && k == 50) begin
        dif.i_start = 1'b1;
        dif.i_op    = ~opv;
      end
      if (do_mid && k == 51) dif.i_start = 1'b0;
      if (stall_left > 0) begin
        if (dif.o_rd_en !== 1'b0 || dif.o_rd_addr !== 8'd10) stall_bad++;
        stall_left--;
        if (stall_left == 0) dif.i_stall = 1'b0;
      end else if (do_stall && !stalled && dif.o_rd_en === 1'b1 && dif.o_rd_addr == 8'd10) begin
        dif.i_stall = 1'b1;
        stall_left  = 5;
        stalled     = 1'b1;
      end
      if (dif.o_rd_en === 1'b1) begin
        n_rd++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
      end
      if (dif.o_wr_en === 1'b1) begin
        n_wr++;
        if (first_wr < 0) first_wr = k;
        last_wr = k;
      end
      if (dif.o_done === 1'b1) begin
        done_k = k;
        chk({tag, "_busy_at_done"}, 32'(dif.o_busy), 32'd0);
        if (chain_next) begin
          dif.i_start = 1'b1;
          dif.i_op    = next_op;
        end
      end else if (dif.o_busy !== 1'b1) begin
        busy_bad++;
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_k), 32'(exp_done));
    chk({tag, "_first_rd"}, 32'(first_rd), 32'd1);
    chk({tag, "_last_rd"}, 32'(last_rd), 32'(exp_done - 3));
    chk({tag, "_first_wr"}, 32'(first_wr), 32'd3);
    chk({tag, "_last_wr"}, 32'(last_wr), 32'(exp_done - 1));
    chk({tag, "_n_rd"}, 32'(n_rd), 32'(N));
    chk({tag, "_n_wr"}, 32'(n_wr), 32'(N));
    chk({tag, "_busy_gaps"}, 32'(busy_bad), 32'd0);
    if (do_stall) chk({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
    if (!chain_next) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(dif.o_done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(dif.o_busy), 32'd0);
    end
  endtask

  task automatic reset_mid();
    int k = 0;
    fill_lin();
    @(negedge clk);
    dif.i_start = 1'b1;
    dif.i_op    = 1'b0;
    @(negedge clk);
    dif.i_start = 1'b0;
    while (k < 300 && !(dif.o_rd_en === 1'b1 && dif.o_rd_addr == 8'd100)) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached_100", 32'(k < 300), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", 32'(dif.o_rd_en), 32'd0);
    chk("mid_rst_rd_addr", 32'(dif.o_rd_addr), 32'd0);
    chk("mid_rst_wr_en", 32'(dif.o_wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(dif.o_wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(dif.o_wr_data), 32'd0);
    chk("mid_rst_busy", 32'(dif.o_busy), 32'd0);
    chk("mid_rst_done", 32'(dif.o_done), 32'd0);
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_hold_done", 32'(dif.o_done), 32'd0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 32'(dif.o_done), 32'd0);
      chk("post_rst_busy", 32'(dif.o_busy), 32'd0);
    end
  endtask

  initial begin
    dif.i_start = 1'b0;
    dif.i_op    = 1'b0;
    dif.i_stall = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 32'(dif.o_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(dif.o_rd_addr), 32'd0);
    chk("rst_wr_en", 32'(dif.o_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(dif.o_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(dif.o_wr_data), 32'd0);
    chk("rst_busy", 32'(dif.o_busy), 32'd0);
    chk("rst_done", 32'(dif.o_done), 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_busy", 32'(dif.o_busy), 32'd0);
      chk("idle_rd_en", 32'(dif.o_rd_en), 32'd0);
    end

    fill_lin();
    run_op("add_lin", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 259);
    fill_sub_corner();
    run_op("sub_mid_start", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 259);
    fill_add_corner_chain();
    run_op("add_stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 264);
    run_op("sub_chained", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 259);
    reset_mid();
    fill_lin();
    run_op("add_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 259);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_addsub_ctrl.md
# poly_addsub_ctrl

Sequencer for coefficient-wise modular addition or subtraction (q = 3329) of two N-coefficient polynomials held in external synchronous RAM. On a start pulse it streams read addresses, applies the mod-q add/sub datapath to each returned coefficient pair, and streams results to a write port, then pulses done. It sits beside the NTT/pointwise-multiply units in the polynomial arithmetic core and handles the polynomial add/sub steps of encryption and decryption.

## Interface

- N, 256, coefficients per polynomial; power of two, at least 4. AW = log2(N) is derived.
- Q, 3329, modulus. Coefficient width is fixed at 12 bits.

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin an operation; accepted only when busy = 0
- op  in  1  0 = add (C = A + B mod Q), 1 = sub (C = A − B mod Q); sampled with an accepted start
- stall  in  1  when high, no new read is issued this cycle
- rd_en  out  1  read strobe to the A and B RAMs
- rd_addr  out  AW  read address, shared by the A and B RAMs
- a_data  in  12  coefficient A; valid one cycle after rd_en
- b_data  in  12  coefficient B; valid one cycle after rd_en
- wr_en  out  1  write strobe to the C RAM
- wr_addr  out  AW  write address
- wr_data  out  12  result coefficient
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle completion pulse

## Operation

- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - On start = 1, latch op, clear the address counter, go to RUN.
  - busy = 0.
- **RUN:**
  - Each cycle with stall = 0: rd_en = 1, rd_addr = counter, then counter increments.
  - Each cycle with stall = 1: rd_en = 0 and the counter holds.
  - After the read of address N−1 is issued, go to DRAIN. The counter does not wrap into a second pass.
- **DRAIN:** wait until both pipeline valid bits are clear, then go to DONE. stall has no effect here.
- **DONE:**
  - done = 1 and busy = 0 for exactly one cycle.
  - If start = 1 in this cycle, latch op, clear the counter and go directly to RUN. Otherwise go to IDLE.
- **start while busy = 1** (RUN or DRAIN) is ignored, and op is not resampled.
- **Pipeline:**
  - Stage-1 valid/address register follows rd_en.
  - Stage-2 register captures the datapath result, the address and the valid bit.
  - In-flight reads always complete, regardless of stall.
  - Writes occur in strictly increasing address order, each address exactly once.
- **Datapath arithmetic** (13-bit internal, no 12-bit overflow):
  - Add: S = A + B (13 bits). If S ≥ Q then C = S − Q, else C = S.
  - Sub: D = A − B (13-bit signed). If D < 0 then C = D + Q, else C = D.
  - Inputs must be < Q, and then the result is always in [0, Q−1]. Inputs ≥ Q give a deterministic but unchecked result.
- **Reset** (at any time, including mid-run):
  - State goes to IDLE and the counter and pipeline valid bits clear.
  - Outputs go to rd_en = 0, rd_addr = 0, wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, done = 0.
  - Pending writes are discarded. No partial completion is signalled.

## Timing

- Call the cycle in which start is accepted c0.
- Read issue: first rd_en in c1 with rd_addr = 0.
- Read-to-write latency: the read issued in cycle t is written in cycle t+2 (wr_en = 1, same address).
- Without stall:
  - rd_en is high c1..cN.
  - wr_en is high c3..c(N+2).
  - done is high in c(N+3).
- Each stalled RUN cycle delays all later reads, writes and done by one cycle.
- busy:
  - Rises in c1.
  - Stays high through the last wr_en cycle.
  - Is low in the done cycle.
- Back-to-back runs: start accepted in the done cycle gives rd_en of the next run in the following cycle, with no idle gap.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- **Reset:** assert reset asynchronously mid-cycle → all outputs 0 immediately; after release, busy = 0 until start.
- **Add, N = 256:** a[i] = i, b[i] = 3328 → wr_data at address 0 is 3328; at address i ≥ 1 it is i−1; rd_en c1..c256, wr_en c3..c258, done pulses in c259.
- **Add/sub corner values:**
  - Add 3328+3328 → 3327; 3328+1 → 0; 1664+1664 → 3328.
  - Sub 5−7 → 3327; 7−5 → 2; 0−0 → 0; 0−3328 → 1.
- **Stall:** stall high for 5 cycles starting when rd_addr = 10 → rd_en low for those 5 cycles and rd_addr holds at 10; writes stay contiguous in address order; done arrives in c264.
- **Start handling:**
  - start pulsed during RUN with the opposite op → ignored; results use the original op.
  - start asserted in the done cycle → the new run's rd_addr = 0 appears the next cycle.
- **Reset mid-run:** reset asserted when rd_addr = 100 → wr_en 0 and busy 0 immediately, no done pulse; the next start restarts from address 0 and completes normally.
